// File: rtl/vga_timing_ctrl.sv
// Parametrised VGA timing generator: integer pixel prescaler, raster
// counters, registered syncs/strobes and a per-frame selectable RGB source.
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int CW       = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 19,
  parameter int H_SYNC   = 97,
  parameter int H_BP     = 44,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 30,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int FRAME_W  = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [3*CW-1:0]    pixel_color,
  output logic [CW-1:0]      vgaRed,
  output logic [CW-1:0]      vgaGreen,
  output logic [CW-1:0]      vgaBlue,
  output logic               Hsync,
  output logic               Vsync,
  output logic [X_W-1:0]     XCoord,
  output logic [Y_W-1:0]     YCoord,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BLACK = 2'd3
  } mode_e;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Narrow screens still get non-zero bars; every pixel then lands in a bar.
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [PW-1:0]  P_LAST   = PW'(CLK_DIV - 1);
  localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEG   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [X_W-1:0] BAR_LAST = X_W'(BAR_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEG   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Elaboration-time sanity on geometry versus counter widths.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
  if ((H_TOTAL - 1) >= (1 << X_W)) begin : g_bad_xw
    $error("H_TOTAL-1 does not fit in X_W");
  end
  if ((V_TOTAL - 1) >= (1 << Y_W)) begin : g_bad_yw
    $error("V_TOTAL-1 does not fit in Y_W");
  end
  if (CHK_LOG2 >= X_W || CHK_LOG2 >= Y_W) begin : g_bad_chk
    $error("CHK_LOG2 must index inside XCoord and YCoord");
  end

  logic [PW-1:0]  pcnt;
  logic           tick;
  logic           x_wrap, y_wrap;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic [X_W-1:0] bar_cnt;
  logic [2:0]     bar_idx;
  mode_e          mode_q;

  assign tick   = en && (pcnt == P_LAST);
  assign x_wrap = (XCoord == X_LAST);
  assign y_wrap = (YCoord == Y_LAST);

  // Next raster position, consumed only on a pixel tick.
  always_comb begin
    x_nxt = XCoord + 1'b1;
    y_nxt = YCoord;
    if (x_wrap) begin
      x_nxt = '0;
      y_nxt = y_wrap ? '0 : YCoord + 1'b1;
    end
  end

  // Pixel prescaler; frozen whenever en is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   pcnt <= '0;
    else if (en) pcnt <= tick ? '0 : pcnt + 1'b1;
  end

  // Raster counters plus every output that must stay aligned with them.
  // Strobes clear each clock so they never stretch when en drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      XCoord      <= '0;
      YCoord      <= '0;
      Hsync       <= ~HS_POL;
      Vsync       <= ~VS_POL;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      mode_q      <= MODE_PASS;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        XCoord      <= x_nxt;
        YCoord      <= y_nxt;
        Hsync       <= (x_nxt >= HS_BEG && x_nxt <= HS_END) ? HS_POL : ~HS_POL;
        Vsync       <= (y_nxt >= VS_BEG && y_nxt <= VS_END) ? VS_POL : ~VS_POL;
        active      <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
        line_start  <= x_wrap;
        frame_start <= x_wrap && y_wrap;
        if (x_wrap && y_wrap) begin
          frame_cnt <= frame_cnt + 1'b1;
          mode_q    <= mode_e'(mode);
        end
      end
    end
  end

  // Colour-bar index tracked alongside X; saturates at the last bar.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (tick) begin
      if (x_wrap) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

  // RGB source select; blanking overrides every mode.
  always_comb begin
    vgaRed   = '0;
    vgaGreen = '0;
    vgaBlue  = '0;
    if (active) begin
      case (mode_q)
        MODE_PASS: begin
          vgaRed   = pixel_color[CW-1:0];
          vgaGreen = pixel_color[2*CW-1:CW];
          vgaBlue  = pixel_color[3*CW-1:2*CW];
        end
        MODE_BARS: begin
          vgaRed   = {CW{bar_idx[0]}};
          vgaGreen = {CW{bar_idx[1]}};
          vgaBlue  = {CW{bar_idx[2]}};
        end
        MODE_CHECK: begin
          if (XCoord[CHK_LOG2] ^ YCoord[CHK_LOG2]) begin
            vgaRed   = '1;
            vgaGreen = '1;
            vgaBlue  = '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default geometry (A), tiny overridden geometry
// with a raster model (B), and table-driven pattern vectors (C).
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural raster model ----------------
  typedef struct packed {
    int div; int hact; int htot; int hs0; int hs1; bit hpol;
    int vact; int vtot; int vs0; int vs1; bit vpol;
    int barw; int chk; int fmod;
    int p; int x; int y; int f; bit [1:0] md; bit ls; bit fs;
  } model_t;

  function automatic model_t m_clk(model_t m, bit en, bit [1:0] mode_in);
    m.ls = 1'b0;
    m.fs = 1'b0;
    if (en) begin
      if (m.p == m.div - 1) begin
        m.p = 0;
        if (m.x == m.htot - 1) begin
          m.x  = 0;
          m.ls = 1'b1;
          if (m.y == m.vtot - 1) begin
            m.y  = 0;
            m.fs = 1'b1;
            m.f  = (m.f + 1) % m.fmod;
            m.md = mode_in;
          end else m.y = m.y + 1;
        end else m.x = m.x + 1;
      end else m.p = m.p + 1;
    end
    return m;
  endfunction

  function automatic logic [11:0] m_rgb(model_t m, logic [11:0] pc);
    int b;
    logic [3:0] r, g, bl;
    if (!(m.x < m.hact && m.y < m.vact)) return 12'h000;
    case (m.md)
      2'd0: return pc;
      2'd1: begin
        b = m.x / m.barw;
        if (b > 7) b = 7;
        r  = b[0] ? 4'hF : 4'h0;
        g  = b[1] ? 4'hF : 4'h0;
        bl = b[2] ? 4'hF : 4'h0;
        return {bl, g, r};
      end
      2'd2: return ((((m.x >> m.chk) ^ (m.y >> m.chk)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic m_check(input string t, input model_t m, input logic [11:0] pc,
                         input int x, input int y, input logic hs, input logic vs,
                         input logic act, input logic ls, input logic fs,
                         input int fc, input logic [11:0] rgb);
    logic ehs, evs;
    ehs = (m.x >= m.hs0 && m.x <= m.hs1) ? m.hpol : ~m.hpol;
    evs = (m.y >= m.vs0 && m.y <= m.vs1) ? m.vpol : ~m.vpol;
    chk({t, ".x"},   x,   m.x);
    chk({t, ".y"},   y,   m.y);
    chk({t, ".hs"},  hs,  ehs);
    chk({t, ".vs"},  vs,  evs);
    chk({t, ".act"}, act, (m.x < m.hact && m.y < m.vact));
    chk({t, ".ls"},  ls,  m.ls);
    chk({t, ".fs"},  fs,  m.fs);
    chk({t, ".fc"},  fc,  m.f);
    chk({t, ".rgb"}, rgb, m_rgb(m, pc));
  endtask

  // ---------------- DUT A: default parameters ----------------
  logic rstA = 1'b0, enA = 1'b1;
  logic [1:0] modeA = 2'd0;
  logic [11:0] pcA = 12'hcba;
  logic [3:0] rA, gA, bA;
  logic hsA, vsA, actA, lsA, fsA;
  logic [9:0] xA, yA;
  logic [7:0] fcA;

  vga_timing_ctrl dut_a (
    .clk(clk), .rstn(rstA), .en(enA), .mode(modeA), .pixel_color(pcA),
    .vgaRed(rA), .vgaGreen(gA), .vgaBlue(bA), .Hsync(hsA), .Vsync(vsA),
    .XCoord(xA), .YCoord(yA), .active(actA), .line_start(lsA),
    .frame_start(fsA), .frame_cnt(fcA));

  // ---------------- DUT B: tiny overridden geometry ----------------
  logic rstB = 1'b0, enB = 1'b1;
  logic [1:0] modeB = 2'd3;
  logic [11:0] pcB = 12'h123;
  logic [3:0] rB, gB, bB;
  logic hsB, vsB, actB, lsB, fsB;
  logic [4:0] xB, yB;
  logic [1:0] fcB;

  vga_timing_ctrl #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1),
    .X_W(5), .Y_W(5), .FRAME_W(2), .CHK_LOG2(1)
  ) dut_b (
    .clk(clk), .rstn(rstB), .en(enB), .mode(modeB), .pixel_color(pcB),
    .vgaRed(rB), .vgaGreen(gB), .vgaBlue(bB), .Hsync(hsB), .Vsync(vsB),
    .XCoord(xB), .YCoord(yB), .active(actB), .line_start(lsB),
    .frame_start(fsB), .frame_cnt(fcB));

  // ---------------- DUT C: mid-size geometry for pattern vectors ----------------
  logic rstC = 1'b0, enC = 1'b1;
  logic [1:0] modeC = 2'd0;
  logic [11:0] pcC = 12'hcba;
  logic [3:0] rC, gC, bC;
  logic hsC, vsC, actC, lsC, fsC;
  logic [9:0] xC, yC;
  logic [7:0] fcC;

  vga_timing_ctrl #(
    .CLK_DIV(1), .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_c (
    .clk(clk), .rstn(rstC), .en(enC), .mode(modeC), .pixel_color(pcC),
    .vgaRed(rC), .vgaGreen(gC), .vgaBlue(bC), .Hsync(hsC), .Vsync(vsC),
    .XCoord(xC), .YCoord(yC), .active(actC), .line_start(lsC),
    .frame_start(fsC), .frame_cnt(fcC));

  typedef struct {
    logic [1:0]  mode;
    int          x;
    int          y;
    logic [11:0] rgb;  // {blue, green, red}
  } vec_t;

  model_t ma, mb;

  task automatic a_step();
    @(posedge clk);
    ma = m_clk(ma, enA, modeA);
    @(negedge clk);
    m_check("A", ma, pcA, xA, yA, hsA, vsA, actA, lsA, fsA, fcA, {bA, gA, rA});
  endtask

  task automatic b_step();
    @(posedge clk);
    mb = m_clk(mb, enB, modeB);
    @(negedge clk);
    m_check("B", mb, pcB, xB, yB, hsB, vsB, actB, lsB, fsB, fcB, {bB, gB, rB});
  endtask

  task automatic wait_xy_c(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if (xC == 10'(x) && yC == 10'(y)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_fs_c(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (fsC) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    vec_t tv[18];
    int   n, guard, fs1, fs2, nfr;
    bit   ok;
    logic [1:0] cur;

    // ======== A: reset, hold, scan, enable freeze, async reset ========
    ma = '{div:4, hact:640, htot:800, hs0:659, hs1:755, hpol:1'b0,
           vact:480, vtot:525, vs0:493, vs1:494, vpol:1'b0,
           barw:80, chk:5, fmod:256, p:0, x:0, y:0, f:0, md:2'd0, ls:1'b0, fs:1'b0};
    modeA = 2'd1;  // requested mid-frame 0: must not show until a frame wrap
    repeat (3) @(negedge clk);
    m_check("A.rst", ma, pcA, xA, yA, hsA, vsA, actA, lsA, fsA, fcA, {bA, gA, rA});
    chk("A.rst_rgb", {bA, gA, rA}, 12'hcba);

    rstA = 1'b1;
    n = 0;
    do begin
      a_step();
      n++;
    end while (xA == 10'd0 && n < 10);
    chk("A.hold_clks", n, 4);

    guard = 0;
    while (!(ma.x == 100 && ma.y == 1) && guard < 20000) begin a_step(); guard++; end
    chk("A.x100", xA, 100);
    enA = 1'b0;
    repeat (50) a_step();
    chk("A.frozen_x", xA, 100);
    chk("A.frozen_y", yA, 1);
    enA = 1'b1;

    // strobe must clear on the next clock even with en dropped
    guard = 0;
    while (!ma.ls && guard < 20000) begin a_step(); guard++; end
    chk("A.ls_seen", lsA, 1'b1);
    enA = 1'b0;
    a_step();
    chk("A.ls_drop", lsA, 1'b0);
    enA = 1'b1;

    guard = 0;
    while (!(ma.x == 700 && ma.y == 2) && guard < 20000) begin a_step(); guard++; end
    chk("A.hs_pre", hsA, 1'b0);
    #2 rstA = 1'b0;
    pcA = 12'h5e3;
    #1;
    chk("A.arst_x", xA, 0);
    chk("A.arst_y", yA, 0);
    chk("A.arst_hs", hsA, 1'b1);
    chk("A.arst_vs", vsA, 1'b1);
    chk("A.arst_fc", fcA, 0);
    chk("A.arst_act", actA, 1'b1);
    chk("A.arst_rgb", {bA, gA, rA}, 12'h5e3);
    ma.p = 0; ma.x = 0; ma.y = 0; ma.f = 0; ma.md = 2'd0; ma.ls = 1'b0; ma.fs = 1'b0;
    @(negedge clk);
    rstA = 1'b1;
    repeat (12) a_step();

    // ======== B: tiny geometry, several frames, all modes ========
    mb = '{div:1, hact:16, htot:24, hs0:18, hs1:20, hpol:1'b1,
           vact:4, vtot:7, vs0:5, vs1:5, vpol:1'b0,
           barw:2, chk:1, fmod:4, p:0, x:0, y:0, f:0, md:2'd0, ls:1'b0, fs:1'b0};
    @(negedge clk);
    m_check("B.rst", mb, pcB, xB, yB, hsB, vsB, actB, lsB, fsB, fcB, {bB, gB, rB});
    chk("B.rst_hs", hsB, 1'b0);
    rstB = 1'b1;
    fs1 = -1; fs2 = -1; nfr = 0;
    for (int s = 1; s < 3000 && nfr < 6; s++) begin
      b_step();
      if (mb.fs) begin
        nfr++;
        if (fs1 < 0) fs1 = s;
        else if (fs2 < 0) fs2 = s;
      end
      pcB   = 12'($urandom);
      modeB = 2'((s / 60 + 3) % 4);
      enB   = (s < 400) ? 1'b1 : ($urandom_range(0, 5) != 0);
    end
    chk("B.first_fs", fs1, 168);
    chk("B.fperiod", fs2 - fs1, 168);
    chk("B.frames", nfr, 6);
    chk("B.fc_wrap", fcB, 2'd2);

    // ======== C: table-driven pattern vectors ========
    tv[0]  = '{2'd0,  0,  0, 12'hcba};
    tv[1]  = '{2'd0, 63, 39, 12'hcba};
    tv[2]  = '{2'd0, 64, 39, 12'h000};
    tv[3]  = '{2'd0,  5, 40, 12'h000};
    tv[4]  = '{2'd1,  0,  0, 12'h000};
    tv[5]  = '{2'd1,  8,  0, 12'h00F};
    tv[6]  = '{2'd1, 16,  0, 12'h0F0};
    tv[7]  = '{2'd1, 31,  0, 12'h0FF};
    tv[8]  = '{2'd1, 63,  0, 12'hFFF};
    tv[9]  = '{2'd1, 39,  1, 12'hF00};
    tv[10] = '{2'd1, 70,  1, 12'h000};
    tv[11] = '{2'd2, 31,  0, 12'h000};
    tv[12] = '{2'd2, 32,  0, 12'hFFF};
    tv[13] = '{2'd2,  0, 32, 12'hFFF};
    tv[14] = '{2'd2, 32, 32, 12'h000};
    tv[15] = '{2'd2, 64, 32, 12'h000};
    tv[16] = '{2'd3, 10, 10, 12'h000};
    tv[17] = '{2'd0, 10, 10, 12'hcba};
    @(negedge clk);
    rstC = 1'b1;
    cur = 2'd0;
    for (int i = 0; i < 18; i++) begin
      if (tv[i].mode != cur) begin
        modeC = tv[i].mode;
        wait_fs_c(ok);
        chk($sformatf("C.fs_wait%0d", i), ok, 1'b1);
        cur = tv[i].mode;
      end
      wait_xy_c(tv[i].x, tv[i].y, ok);
      chk($sformatf("C.xy_wait%0d", i), ok, 1'b1);
      chk($sformatf("C.rgb%0d", i), {bC, gC, rC}, tv[i].rgb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
